// File: rtl/crd_pkg.sv
// Shared constants for the 8b/10b receive lane: K28.5 comma patterns and the
// lock-controller state encoding.
package crd_pkg;

    localparam logic [9:0] K28_5_RDN = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;

    typedef enum logic [1:0] {
        LOS  = 2'd0,
        ACQ  = 2'd1,
        SYNC = 2'd2
    } sync_state_e;

    function automatic logic is_comma(input logic [9:0] sym);
        return (sym == K28_5_RDN) || (sym == K28_5_RDP);
    endfunction

endpackage

// File: rtl/crd_comma_det.sv
// K28.5 comma match on the incoming symbol, registered into the stage-1 flags
// so they line up with the disparity checker's one-cycle-late error report.
import crd_pkg::*;

module crd_comma_det #(
    parameter int iWIDTH = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [iWIDTH-1:0] data_in,
    input  logic              din_valid,
    output logic              comma_d1,
    output logic              vld_d1
);

    logic comma;

    assign comma = din_valid & is_comma(data_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            comma_d1 <= 1'b0;
            vld_d1   <= 1'b0;
        end else begin
            comma_d1 <= comma;
            vld_d1   <= din_valid;
        end
    end

endmodule

// File: rtl/crd_sync_ctrl.sv
// Symbol-lock controller: reseeds the crd checker on the first comma, locks after
// ACQ_COMMAS commas and drops lock when disparity errors outpace clean symbols.
import crd_pkg::*;

module crd_sync_ctrl #(
    parameter int iWIDTH     = 10,
    parameter int ACQ_COMMAS = 2,
    parameter int ERR_THRESH = 4,
    parameter int GOOD_RUN   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [iWIDTH-1:0] data_in,
    input  logic              din_valid,
    input  logic              crd_err,
    output logic              crd_rst,
    output logic              sync_ok,
    output logic [1:0]        state,
    output logic [15:0]       err_total
);

    localparam int CW = $clog2(ACQ_COMMAS + 1);
    localparam int EW = $clog2(ERR_THRESH + 1);
    localparam int GW = $clog2(GOOD_RUN + 1);

    localparam logic [CW-1:0] ACQ_C  = CW'(ACQ_COMMAS);
    localparam logic [EW-1:0] THR_C  = EW'(ERR_THRESH);
    localparam logic [GW-1:0] GOOD_C = GW'(GOOD_RUN);

    sync_state_e   state_q;
    logic          comma_d1;
    logic          vld_d1;
    logic          crd_rst_d1;
    logic          mask;
    logic          qerr;
    logic [CW-1:0] comma_cnt;
    logic [EW-1:0] err_cnt;
    logic [GW-1:0] good_cnt;
    logic [CW-1:0] comma_inc;
    logic [EW-1:0] err_inc;
    logic [GW-1:0] good_inc;

    crd_comma_det #(
        .iWIDTH(iWIDTH)
    ) u_comma_det (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .din_valid(din_valid),
        .comma_d1 (comma_d1),
        .vld_d1   (vld_d1)
    );

    // The checker's error flag is meaningless while it is being reseeded and for
    // the symbol right after, so both cycles are blanked.
    assign mask      = crd_rst | crd_rst_d1;
    assign qerr      = crd_err & vld_d1 & ~mask;
    assign comma_inc = comma_cnt + CW'(1);
    assign err_inc   = err_cnt + EW'(1);
    assign good_inc  = good_cnt + GW'(1);
    assign state     = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOS;
            sync_ok    <= 1'b0;
            crd_rst    <= 1'b1;
            crd_rst_d1 <= 1'b1;
            comma_cnt  <= '0;
            err_cnt    <= '0;
            good_cnt   <= '0;
            err_total  <= '0;
        end else begin
            crd_rst    <= 1'b0;
            crd_rst_d1 <= crd_rst;
            if (vld_d1) begin
                unique case (state_q)
                    LOS: begin
                        if (comma_d1) begin
                            crd_rst <= 1'b1;
                            if (ACQ_COMMAS == 1) begin
                                state_q   <= SYNC;
                                sync_ok   <= 1'b1;
                                comma_cnt <= '0;
                                err_cnt   <= '0;
                                good_cnt  <= '0;
                            end else begin
                                state_q   <= ACQ;
                                comma_cnt <= CW'(1);
                            end
                        end
                    end
                    ACQ: begin
                        if (qerr) begin
                            state_q   <= LOS;
                            comma_cnt <= '0;
                        end else if (comma_d1) begin
                            if (comma_inc == ACQ_C) begin
                                state_q   <= SYNC;
                                sync_ok   <= 1'b1;
                                comma_cnt <= '0;
                                err_cnt   <= '0;
                                good_cnt  <= '0;
                            end else begin
                                comma_cnt <= comma_inc;
                            end
                        end
                    end
                    SYNC: begin
                        if (qerr) begin
                            if (err_total != 16'hFFFF) begin
                                err_total <= err_total + 16'd1;
                            end
                            good_cnt <= '0;
                            if (err_inc == THR_C) begin
                                state_q <= LOS;
                                sync_ok <= 1'b0;
                                err_cnt <= '0;
                            end else begin
                                err_cnt <= err_inc;
                            end
                        end else if (good_inc == GOOD_C) begin
                            // A full clean run forgives one earlier error.
                            good_cnt <= '0;
                            if (err_cnt != '0) begin
                                err_cnt <= err_cnt - EW'(1);
                            end
                        end else begin
                            good_cnt <= good_inc;
                        end
                    end
                    default: begin
                        state_q <= LOS;
                        sync_ok <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/crd_sync_ctrl.md
# crd_sync_ctrl

Receive-side symbol-lock controller for the 10-bit 8b/10b lane. It sits beside the existing `crd` running-disparity checker and sequences it. It:
- watches incoming symbols for K28.5 commas;
- reseeds the checker on the first comma;
- declares lock after a programmable number of commas;
- drops lock when disparity errors reported by the checker accumulate faster than clean symbols drain them.

Downstream logic gates symbol consumption on `sync_ok`.

## Interface

Parameters:
- `iWIDTH`, 10: symbol width; fixed at 10, the parameter exists for consistency with `crd`.
- `ACQ_COMMAS`, 2: commas, including the first, needed to move from ACQ to SYNC; range 1..15.
- `ERR_THRESH`, 4: error-counter value that forces loss of sync; range 2..15.
- `GOOD_RUN`, 4: consecutive clean symbols that decrement the error counter; range 1..255.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `data_in` in 10: received symbol; bit 9 is the first transmitted bit 'a'.
- `din_valid` in 1: `data_in` holds a symbol this cycle.
- `crd_err` in 1: from `crd`; disparity error for the symbol presented one cycle earlier.
- `crd_rst` out 1: registered reset to `crd`.
- `sync_ok` out 1: high only in SYNC.
- `state` out 2: 0=LOS, 1=ACQ, 2=SYNC.
- `err_total` out 16: saturating count of qualified errors taken while in SYNC.

## Operation

Comma detect:
- comma = `din_valid` & (`data_in` == 10'b0011111010 | `data_in` == 10'b1100000101).
- comma and `din_valid` are registered as stage-1 flags `comma_d1` and `vld_d1`.
- All state decisions are made at stage 1, aligned with `crd_err`.

Error qualification:
- `qerr` = `crd_err` & `vld_d1` & ~`mask`.
- `mask` is high in the cycle `crd_rst` is high and the following cycle.

LOS:
- Ignores `crd_err`.
- On `comma_d1`: pulse `crd_rst` for one cycle, set `comma_cnt` to 1, go to ACQ.
- If `ACQ_COMMAS` = 1, go directly to SYNC instead.

ACQ:
- `qerr` → LOS; `comma_cnt` cleared.
- Otherwise `comma_d1` increments `comma_cnt`; reaching `ACQ_COMMAS` → SYNC with `err_cnt` = 0 and `good_cnt` = 0.
- `qerr` and `comma_d1` in the same cycle: the error wins.

SYNC:
- `qerr`:
  - `err_cnt` + 1 and `good_cnt` cleared;
  - `err_total` + 1, saturating at 16'hFFFF;
  - if `err_cnt` + 1 == `ERR_THRESH` → LOS with `err_cnt` and `good_cnt` cleared.
- Clean symbol (`vld_d1` & ~`qerr`):
  - `good_cnt` + 1;
  - when it reaches `GOOD_RUN`: `good_cnt` cleared and `err_cnt` decremented if nonzero.
- Commas in SYNC are ordinary clean symbols; they never reseed.

`vld_d1` low: every counter and the state hold.

`err_total` is cleared only by `rst`; it is never cleared by loss of sync.

## Timing

- Symbol at edge t is judged at edge t+1.
- `state`, `sync_ok` and `crd_rst` change at edge t+2, i.e. they become visible in the cycle after stage 1.
- `crd_rst` is high for exactly one cycle per LOS→ACQ/SYNC transition.
- Lock latency from the final required comma to `sync_ok` = 2 edges.
- Loss latency from the error-carrying symbol to `sync_ok` low = 2 edges.
- `rst` high at an edge:
  - state = LOS;
  - `sync_ok` = 0, `err_total` = 0;
  - `comma_cnt`, `err_cnt`, `good_cnt`, stage-1 flags = 0;
  - `crd_rst` = 1, so `crd` is reset alongside.
- On the first edge after `rst` falls, `crd_rst` returns to 0.
- Reset asserted mid-SYNC or mid-ACQ discards all progress; nothing survives except parameters.

## Structure

- Shared package `crd_pkg`:
  - K28.5 RD− and RD+ constants;
  - state encoding `LOS`/`ACQ`/`SYNC` as a 2-bit localparam set.
- Counter widths: `$clog2` of `ACQ_COMMAS`+1, `ERR_THRESH`+1 and `GOOD_RUN`+1.
- One natural sub-module, `crd_comma_det`: combinational comma match plus the stage-1 register.
- `crd` is not instantiated here; the top level wires `crd_rst` → `crd.rst` and `crd.err` → `crd_err`.

## Test plan

- Reset, then 3 cycles idle with `din_valid` = 0 → `crd_rst` 1 during reset and 0 afterwards; `state` = 0, `err_total` = 0.
- Sequence: 10'b0011111010, data symbol, 10'b1100000101, no errors → `crd_rst` pulses once two edges after the first comma; `state` 1 then 2; `sync_ok` high two edges after the second comma.
- In ACQ, assert `crd_err` aligned to a non-comma symbol → return to LOS; a fresh comma then produces a second `crd_rst` pulse.
- In SYNC with `ERR_THRESH` = 4, `GOOD_RUN` = 4: errors on symbols 1, 2, 3 → `err_cnt` = 3; symbol 4 error → LOS, `sync_ok` low, `err_total` = 4.
- In SYNC: one error followed by 4 clean symbols → `err_cnt` 1→0; then 3 errors → still SYNC; a 4th error → LOS.
- Assert `rst` for one edge while in SYNC with `err_total` = 5 → next cycle `state` = 0, `err_total` = 0, `crd_rst` = 1 for that cycle.
